mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch stage and the data-memory (MEM) stage of the pipelined core.
- Accepts one request at a time from either requester and forwards it to the memory bus.
- Waits a variable number of cycles for the memory acknowledge, then routes the response back to the owning requester.
- Exports stall signals that feed the PC hold and the pipeline-register enables.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 64, max cycles mem_req may stay high without mem_ack before abort
MAX_DM_STREAK, 4, consecutive DM grants with IF pending before IF is favoured (used only with ARB_FAIRNESS_EN)

Ports:
clk  in  1  clock
rst  in  1  reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  one-cycle accept pulse to fetch
if_rvalid  out  1  one-cycle response pulse to fetch
if_rdata  out  DW  fetched instruction, valid with if_rvalid
dm_req  in  1  data request; held with dm_we/addr/wdata/wstrb until dm_gnt
dm_we  in  1  1 = write
dm_addr  in  AW  data address
dm_wdata  in  DW  write data
dm_wstrb  in  DW/8  byte enables
dm_gnt  out  1  one-cycle accept pulse to MEM stage
dm_rvalid  out  1  one-cycle completion pulse (reads and writes)
dm_rdata  out  DW  read data; 0 for writes
err  out  1  one-cycle pulse with rvalid when the transaction timed out
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_wstrb  out  DW/8  memory byte enables
mem_ack  in  1  memory completion, single cycle
mem_rdata  in  DW  memory read data, valid with mem_ack
stall_if  out  1  if_req pending and not granted this cycle, or fetch outstanding
stall_dm  out  1  dm_req pending and not granted this cycle, or data access outstanding

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- States:
  - IDLE
  - BUSY (owner register: IF or DM)
- IDLE:
  - Grant is combinational.
  - Default priority: DM over IF, because MEM is older in program order.
  - The grant pulse (if_gnt or dm_gnt) is high in the same cycle N the request is seen.
  - Address, data, we and wstrb are latched at the N edge.
  - Next state is BUSY.
  - mem_req and the mem_* fields are registered high from N+1.
  - IF grants drive mem_we=0 and mem_wstrb=0.
- BUSY:
  - mem_* outputs are held stable; no grants are issued.
  - mem_ack sampled high at cycle M:
    - mem_req drops at M+1.
    - Owner's rvalid pulses at M+1; rdata is registered from mem_rdata (dm_rdata=0 for writes).
    - State returns to IDLE at M+1.
- Back-to-back: in the M+1 cycle the arbiter is IDLE and may grant a new request while rvalid is high. Minimum period is 3 cycles per transaction for a 1-cycle-ack memory.
- Timeout:
  - A counter clears at grant and increments each BUSY cycle without mem_ack.
  - When it reaches TIMEOUT: mem_req drops next cycle, owner rvalid and err pulse together, rdata=0, return to IDLE.
  - A mem_ack arriving in the same cycle as expiry wins: normal completion, no err.
- Simultaneous if_req and dm_req in IDLE: dm_gnt only; IF stays stalled.
- A request deasserted before grant is a protocol violation; behaviour is unspecified and is covered by a bench assertion.
- Reset:
  - While rst is high: if_gnt=dm_gnt=0 combinationally.
  - At the rst edge: state IDLE; all registered outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_rvalid, dm_rvalid, if_rdata, dm_rdata, err).
  - An in-flight transaction is dropped with no rvalid.
  - A late mem_ack after reset is ignored.
  - stall_if and stall_dm are 0 while rst is high.

Optional Feature:
ARB_FAIRNESS_EN
- Defined:
  - A streak counter increments on each DM grant made while if_req is high.
  - It clears on any IF grant, or on a DM grant made with if_req low.
  - When the streak equals MAX_DM_STREAK and both requests are present, IF is granted instead.
- Undefined: strict DM priority, no streak counter; MAX_DM_STREAK is ignored.

Decomposition:
- Shared package core_pkg:
  - arbiter state encoding (ARB_IDLE, ARB_BUSY)
  - owner encoding (OWN_IF=0, OWN_DM=1)
  - default AW/DW constants, reused by the core top and memory models
- One natural sub-module, mem_arb_pick:
  - Combinational priority/fairness select: inputs if_req, dm_req, streak_hit; outputs grant_if, grant_dm.
  - The fairness logic is isolated there.

Test Plan:
1. IF read 0x100, memory acks 2 cycles after mem_req, rdata 0x00500093 -> if_gnt at N; mem_req high N+1..N+3; if_rvalid at N+4 with if_rdata=0x00500093; stall_if high N+1..N+3.
2. if_req and dm_req (write 0x2000, data 0xDEADBEEF, wstrb 0xF) in the same cycle -> dm_gnt only; mem_we=1, mem_addr=0x2000; after dm_rvalid (dm_rdata=0), if_gnt the same cycle.
3. mem_ack never asserted, TIMEOUT=64 -> mem_req high exactly 64 cycles; dm_rvalid and err pulse together; next request granted normally.
4. rst asserted 2 cycles into a BUSY DM read, mem_ack arrives 1 cycle after rst deasserts -> no dm_rvalid, all outputs 0, state IDLE, stray ack ignored.
5. ARB_FAIRNESS_EN, MAX_DM_STREAK=4, both requests held continuously -> grant order DM,DM,DM,DM,IF,DM...; without the macro, IF is never granted.
6. Back-to-back DM reads 0x10, 0x14 with 1-cycle ack -> grants 3 cycles apart; rdata returned in order with no lost rvalid.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared core encodings: arbiter state, request owner and the default bus widths
// used by the core top, the arbiter and the memory models.
package core_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port, memory bus and stall outputs of the arbiter.
// slave = arbiter view, master = core/memory environment view.
interface mem_port_arbiter_if
    import core_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;

    logic            dm_req;
    logic            dm_we;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic [DW/8-1:0] dm_wstrb;
    logic            dm_gnt;
    logic            dm_rvalid;
    logic [DW-1:0]   dm_rdata;
    logic            err;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wstrb;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;

    logic            stall_if;
    logic            stall_dm;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  mem_ack, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata, err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output stall_if, stall_dm
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output mem_ack, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata, err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  stall_if, stall_dm
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant select: DM wins over IF unless the DM streak limit is hit
// while both requesters are waiting.
module mem_arb_pick
    import core_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic streak_hit,
    output logic grant_if,
    output logic grant_dm
);

    always_comb begin
        grant_dm = dm_req && !(if_req && streak_hit);
        grant_if = if_req && !grant_dm;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM stage.
// Define ARB_FAIRNESS_EN to let IF win after MAX_DM_STREAK consecutive contended DM grants.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int AW            = AW_DEF,
    parameter int DW            = DW_DEF,
    parameter int TIMEOUT       = 64,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e      state_q, state_d;
    arb_owner_e      owner_q, owner_d;
    logic [CW-1:0]   tcnt_q, tcnt_d;

    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW/8-1:0] mem_wstrb_q, mem_wstrb_d;

    logic            if_rvalid_q, if_rvalid_d;
    logic            dm_rvalid_q, dm_rvalid_d;
    logic            err_q, err_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   dm_rdata_q, dm_rdata_d;

    logic            can_grant;
    logic            grant_if, grant_dm;
    logic            streak_hit;

    // Grants only exist in IDLE and are forced low while reset is held.
    assign can_grant = !rst && (state_q == ARB_IDLE);

    mem_arb_pick u_pick (
        .if_req     (bus.if_req && can_grant),
        .dm_req     (bus.dm_req && can_grant),
        .streak_hit (streak_hit),
        .grant_if   (grant_if),
        .grant_dm   (grant_dm)
    );

`ifdef ARB_FAIRNESS_EN
    localparam int SW = $clog2(MAX_DM_STREAK + 1);

    logic [SW-1:0] streak_q, streak_d;

    always_comb begin
        streak_d = streak_q;
        if (grant_if) begin
            streak_d = '0;
        end else if (grant_dm) begin
            streak_d = bus.if_req ? streak_q + SW'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign streak_hit = (streak_q == SW'(MAX_DM_STREAK));
`else
    // Strict DM priority: the streak limit can never be reached.
    assign streak_hit = (MAX_DM_STREAK < 0);
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        tcnt_d      = tcnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (grant_dm) begin
                    state_d     = ARB_BUSY;
                    owner_d     = OWN_DM;
                    tcnt_d      = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    mem_wstrb_d = bus.dm_wstrb;
                end else if (grant_if) begin
                    state_d     = ARB_BUSY;
                    owner_d     = OWN_IF;
                    tcnt_d      = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                end
            end

            ARB_BUSY: begin
                // An ack in the expiry cycle still completes normally.
                if (bus.mem_ack) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_DM) begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = mem_we_q ? '0 : bus.mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.mem_rdata;
                    end
                end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (owner_q == OWN_DM) begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = '0;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = '0;
                    end
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            tcnt_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            tcnt_q      <= tcnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign bus.if_gnt    = grant_if;
    assign bus.dm_gnt    = grant_dm;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.err       = err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;

    assign bus.stall_if = !rst && ((bus.if_req && !grant_if) ||
                                   (state_q == ARB_BUSY && owner_q == OWN_IF));
    assign bus.stall_dm = !rst && ((bus.dm_req && !grant_dm) ||
                                   (state_q == ARB_BUSY && owner_q == OWN_DM));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, IF read, contention, back-to-back,
// timeout, reset mid-transaction and DM/IF grant ordering.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW            (32),
        .DW            (32),
        .TIMEOUT       (64),
        .MAX_DM_STREAK (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // A request may only be withdrawn after it has been granted.
    logic if_wait = 1'b0;
    logic dm_wait = 1'b0;
    always @(negedge clk) begin
        assert (!(if_wait && !bus.if_req && !rst)) else $error("protocol: if_req dropped before if_gnt");
        assert (!(dm_wait && !bus.dm_req && !rst)) else $error("protocol: dm_req dropped before dm_gnt");
        if_wait = !rst && bus.if_req && !bus.if_gnt;
        dm_wait = !rst && bus.dm_req && !bus.dm_gnt;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [6:0] exp_dm;

        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.dm_wstrb  = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        // Reset: requests present but no grants or stalls while rst is high
        cyc(); cyc();
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        settle();
        check_eq("rst_if_gnt",   64'(bus.if_gnt),   64'(0));
        check_eq("rst_dm_gnt",   64'(bus.dm_gnt),   64'(0));
        check_eq("rst_stall_if", 64'(bus.stall_if), 64'(0));
        check_eq("rst_stall_dm", 64'(bus.stall_dm), 64'(0));
        check_eq("rst_mem_req",  64'(bus.mem_req),  64'(0));
        check_eq("rst_err",      64'(bus.err),      64'(0));
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        $display("[TB] reset released");

        // T1: IF read 0x100, ack two cycles after mem_req rises
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        settle();
        check_eq("t1_if_gnt",    64'(bus.if_gnt),   64'(1));
        check_eq("t1_dm_gnt",    64'(bus.dm_gnt),   64'(0));
        check_eq("t1_stall_n",   64'(bus.stall_if), 64'(0));
        cyc();
        bus.if_req = 1'b0;
        settle();
        check_eq("t1_req_n1",    64'(bus.mem_req),   64'(1));
        check_eq("t1_addr",      64'(bus.mem_addr),  64'h100);
        check_eq("t1_we",        64'(bus.mem_we),    64'(0));
        check_eq("t1_wstrb",     64'(bus.mem_wstrb), 64'(0));
        check_eq("t1_stall_n1",  64'(bus.stall_if),  64'(1));
        cyc();
        settle();
        check_eq("t1_req_n2",    64'(bus.mem_req),   64'(1));
        check_eq("t1_stall_n2",  64'(bus.stall_if),  64'(1));
        check_eq("t1_rvalid_n2", 64'(bus.if_rvalid), 64'(0));
        cyc();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0050_0093;
        settle();
        check_eq("t1_req_n3",    64'(bus.mem_req),  64'(1));
        check_eq("t1_stall_n3",  64'(bus.stall_if), 64'(1));
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        settle();
        check_eq("t1_req_n4",    64'(bus.mem_req),   64'(0));
        check_eq("t1_rvalid",    64'(bus.if_rvalid), 64'(1));
        check_eq("t1_rdata",     64'(bus.if_rdata),  64'h0050_0093);
        check_eq("t1_stall_n4",  64'(bus.stall_if),  64'(0));
        check_eq("t1_err",       64'(bus.err),       64'(0));
        cyc();
        settle();
        check_eq("t1_rvalid_n5", 64'(bus.if_rvalid), 64'(0));
        $display("[TB] T1 IF read 0x100 -> 0x%08h", bus.if_rdata);

        // T2: simultaneous IF read and DM write, DM wins
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h300;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h2000;
        bus.dm_wdata = 32'hDEAD_BEEF;
        bus.dm_wstrb = 4'hF;
        settle();
        check_eq("t2_dm_gnt",   64'(bus.dm_gnt),   64'(1));
        check_eq("t2_if_gnt",   64'(bus.if_gnt),   64'(0));
        check_eq("t2_stall_if", 64'(bus.stall_if), 64'(1));
        check_eq("t2_stall_dm", 64'(bus.stall_dm), 64'(0));
        cyc();
        bus.dm_req = 1'b0;
        bus.dm_we  = 1'b0;
        settle();
        check_eq("t2_we",       64'(bus.mem_we),    64'(1));
        check_eq("t2_addr",     64'(bus.mem_addr),  64'h2000);
        check_eq("t2_wdata",    64'(bus.mem_wdata), 64'hDEAD_BEEF);
        check_eq("t2_wstrb",    64'(bus.mem_wstrb), 64'hF);
        check_eq("t2_if_busy",  64'(bus.if_gnt),    64'(0));
        cyc();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        settle();
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        settle();
        check_eq("t2_dm_rvalid", 64'(bus.dm_rvalid), 64'(1));
        check_eq("t2_dm_rdata",  64'(bus.dm_rdata),  64'(0));
        check_eq("t2_if_gnt2",   64'(bus.if_gnt),    64'(1));
        check_eq("t2_err",       64'(bus.err),       64'(0));
        $display("[TB] T2 DM write 0x2000 done, IF granted in completion cycle");
        cyc();
        bus.if_req = 1'b0;
        settle();
        check_eq("t2_if_addr",  64'(bus.mem_addr),  64'h300);
        check_eq("t2_if_we",    64'(bus.mem_we),    64'(0));
        check_eq("t2_if_wstrb", 64'(bus.mem_wstrb), 64'(0));
        cyc();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1111_2222;
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        settle();
        check_eq("t2_if_rvalid", 64'(bus.if_rvalid), 64'(1));
        check_eq("t2_if_rdata",  64'(bus.if_rdata),  64'h1111_2222);
        $display("[TB] T2 IF read 0x300 -> 0x%08h", bus.if_rdata);

        // T6: back-to-back DM reads 0x10, 0x14 with a one-cycle ack
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h10;
        settle();
        check_eq("t6_gnt0",    64'(bus.dm_gnt), 64'(1));
        cyc();
        bus.dm_addr = 32'h14;
        settle();
        check_eq("t6_addr0",   64'(bus.mem_addr), 64'h10);
        check_eq("t6_nogntA",  64'(bus.dm_gnt),   64'(0));
        cyc();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hA0;
        settle();
        check_eq("t6_nogntB",  64'(bus.dm_gnt), 64'(0));
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        settle();
        check_eq("t6_rvalid0", 64'(bus.dm_rvalid), 64'(1));
        check_eq("t6_rdata0",  64'(bus.dm_rdata),  64'hA0);
        check_eq("t6_gnt1",    64'(bus.dm_gnt),    64'(1));
        $display("[TB] T6 DM read 0x10 -> 0x%0h", bus.dm_rdata);
        cyc();
        bus.dm_req = 1'b0;
        settle();
        check_eq("t6_addr1",   64'(bus.mem_addr),  64'h14);
        check_eq("t6_rv_low",  64'(bus.dm_rvalid), 64'(0));
        cyc();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hB0;
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        settle();
        check_eq("t6_rvalid1", 64'(bus.dm_rvalid), 64'(1));
        check_eq("t6_rdata1",  64'(bus.dm_rdata),  64'hB0);
        $display("[TB] T6 DM read 0x14 -> 0x%0h", bus.dm_rdata);

        // T3: no ack ever, timeout after 64 cycles of mem_req
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h40;
        settle();
        check_eq("t3_gnt", 64'(bus.dm_gnt), 64'(1));
        cyc();
        bus.dm_req = 1'b0;
        settle();
        n = 0;
        while (bus.mem_req === 1'b1 && n < 200) begin
            n++;
            cyc();
            settle();
        end
        check_eq("t3_req_cycles", 64'(n),             64'(64));
        check_eq("t3_rvalid",     64'(bus.dm_rvalid), 64'(1));
        check_eq("t3_err",        64'(bus.err),       64'(1));
        check_eq("t3_rdata",      64'(bus.dm_rdata),  64'(0));
        $display("[TB] T3 DM read 0x40 timed out after %0d cycles", n);
        cyc();
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h44;
        settle();
        check_eq("t3_err_low", 64'(bus.err),    64'(0));
        check_eq("t3_regnt",   64'(bus.dm_gnt), 64'(1));
        cyc();
        bus.dm_req = 1'b0;
        cyc();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_0044;
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        settle();
        check_eq("t3_rv2",    64'(bus.dm_rvalid), 64'(1));
        check_eq("t3_err2",   64'(bus.err),       64'(0));
        check_eq("t3_rdata2", 64'(bus.dm_rdata),  64'hCAFE_0044);
        $display("[TB] T3 DM read 0x44 -> 0x%08h", bus.dm_rdata);

        // T4: reset two cycles into a DM read, then a stray ack
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h80;
        settle();
        check_eq("t4_gnt", 64'(bus.dm_gnt), 64'(1));
        cyc();
        bus.dm_req = 1'b0;
        cyc();
        rst = 1'b1;
        settle();
        check_eq("t4_stall_dm_rst", 64'(bus.stall_dm), 64'(0));
        check_eq("t4_stall_if_rst", 64'(bus.stall_if), 64'(0));
        cyc();
        rst = 1'b0;
        settle();
        check_eq("t4_mem_req",  64'(bus.mem_req),   64'(0));
        check_eq("t4_mem_addr", 64'(bus.mem_addr),  64'(0));
        check_eq("t4_mem_we",   64'(bus.mem_we),    64'(0));
        check_eq("t4_dm_rdata", 64'(bus.dm_rdata),  64'(0));
        check_eq("t4_if_rdata", 64'(bus.if_rdata),  64'(0));
        check_eq("t4_dm_rv",    64'(bus.dm_rvalid), 64'(0));
        cyc();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234;
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        settle();
        check_eq("t4_stray_rv",  64'(bus.dm_rvalid), 64'(0));
        check_eq("t4_stray_req", 64'(bus.mem_req),   64'(0));
        check_eq("t4_stray_err", 64'(bus.err),       64'(0));
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h84;
        settle();
        check_eq("t4_idle_gnt", 64'(bus.dm_gnt), 64'(1));
        cyc();
        bus.dm_req = 1'b0;
        cyc();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5678;
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        settle();
        check_eq("t4_rv",    64'(bus.dm_rvalid), 64'(1));
        check_eq("t4_rdata", 64'(bus.dm_rdata),  64'h5678);
        $display("[TB] T4 reset dropped in-flight read, DM read 0x84 -> 0x%0h", bus.dm_rdata);

        // T5: both requesters held; bit t = 1 means grant t goes to DM
`ifdef ARB_FAIRNESS_EN
        exp_dm = 7'b110_1111;
`else
        exp_dm = 7'b111_1111;
`endif
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h200;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h400;
        for (int t = 0; t < 7; t++) begin
            settle();
            check_eq($sformatf("t5_dm_gnt%0d", t), 64'(bus.dm_gnt), 64'(exp_dm[t]));
            check_eq($sformatf("t5_if_gnt%0d", t), 64'(bus.if_gnt), 64'(!exp_dm[t]));
            $display("[TB] T5 grant %0d -> %s", t, bus.dm_gnt ? "DM" : (bus.if_gnt ? "IF" : "none"));
            cyc();
            if (t == 6) bus.dm_req = 1'b0;
            cyc();
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'(t);
            cyc();
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
        end
        settle();
        check_eq("t5_if_final", 64'(bus.if_gnt), 64'(1));
        cyc();
        bus.if_req = 1'b0;
        cyc();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_0013;
        cyc();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        settle();
        check_eq("t5_if_rv",    64'(bus.if_rvalid), 64'(1));
        check_eq("t5_if_rdata", 64'(bus.if_rdata),  64'h13);
        $display("[TB] T5 IF read 0x400 -> 0x%08h", bus.if_rdata);

        cyc();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
